// File: rtl/seq_detector_prog.sv
// seq_detector_prog: programmable serial pattern detector.
// A pattern of 1..MAX_LEN bits (MSB received first) is loaded at run time.
// Serial bits are shifted into a history register. A match is reported as a
// registered one-cycle pulse, and a saturating match counter is kept.
// Overlapping and non-overlapping detection are both supported.
module seq_detector_prog #(
    parameter int MAX_LEN = 8,  // legal range 2..16
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [4:0]         len,
    input  logic               ovl,
    input  logic               din_valid,
    input  logic               din,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               armed
);

    // MAX_LEN expressed in the 5-bit width used for len, len_cfg and fill.
    localparam logic [4:0] MAX_LEN_L = 5'(MAX_LEN);

    typedef enum logic {
        IDLE  = 1'b0,   // no usable configuration, serial input ignored
        ARMED = 1'b1    // pattern loaded, detecting
    } state_t;

    state_t             state, state_next;

    // Configuration captured on load.
    logic [MAX_LEN-1:0] pat_cfg, pat_cfg_next;
    logic [4:0]         len_cfg, len_cfg_next;
    logic               ovl_cfg, ovl_cfg_next;

    // Detection datapath. fill counts the bits that can still take part in a
    // match. It saturates at MAX_LEN and is zeroed after a non-overlapping
    // match, so bits are never shared between matches.
    logic [MAX_LEN-1:0] hist, hist_next;
    logic [4:0]         fill, fill_next;
    logic               match_next;
    logic [CNT_W-1:0]   cnt_next;

    // Helper terms.
    logic [4:0]         len_clamp;
    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN-1:0] len_mask;
    logic [4:0]         fill_inc;
    logic               hit;

    // Oversized lengths are clamped once, when the configuration is captured.
    assign len_clamp  = (len > MAX_LEN_L) ? MAX_LEN_L : len;

    // History after accepting the current bit. The newest bit goes in at
    // bit 0, so pattern bit 0 is compared with the most recent sample.
    assign hist_shift = {hist[MAX_LEN-2:0], din};

    // Fill count after accepting the current bit. It saturates at MAX_LEN.
    assign fill_inc   = (fill == MAX_LEN_L) ? fill : fill + 5'd1;

    // Build a mask that selects the low len_cfg bits of history and pattern.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (5'(i) < len_cfg);
        end
    end

    // Match condition: enough fresh bits, and the low len_cfg bits agree.
    assign hit = (len_cfg != 5'd0) && (fill_inc >= len_cfg) &&
                 (((hist_shift ^ pat_cfg) & len_mask) == '0);

    // State register. armed is registered from the next state, so it always
    // equals (state == ARMED).
    // NOTE: asynchronous reset sits in the sensitivity list; every flop in
    // this design, including the configuration registers, has a defined
    // value coming out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so that
            // all flops update together from values sampled before the edge.
            state <= state_next;
            armed <= (state_next == ARMED);
        end
    end

    // Next-state, configuration capture, history update and match decision.
    always_comb begin
        // NOTE: every signal gets its default value first, so no path leaves
        // one unassigned and no latch is inferred.
        state_next   = state;
        pat_cfg_next = pat_cfg;
        len_cfg_next = len_cfg;
        ovl_cfg_next = ovl_cfg;
        hist_next    = hist;
        fill_next    = fill;
        match_next   = 1'b0;

        if (load) begin
            // A new configuration restarts detection. A din_valid sample in
            // the same cycle is dropped.
            pat_cfg_next = pat;
            len_cfg_next = len_clamp;
            ovl_cfg_next = ovl;
            hist_next    = '0;
            fill_next    = 5'd0;
            state_next   = (len == 5'd0) ? IDLE : ARMED;
        end else if ((state == ARMED) && din_valid) begin
            hist_next = hist_shift;
            if (hit) begin
                match_next = 1'b1;
                fill_next  = ovl_cfg ? fill_inc : 5'd0;
            end else begin
                fill_next  = fill_inc;
            end
        end
    end

    // Match counter: a clear wins over a simultaneous increment. The count
    // saturates at its maximum, and load leaves it untouched.
    always_comb begin
        cnt_next = match_cnt;
        if (cnt_clr) begin
            cnt_next = '0;
        end else if (match_next && (match_cnt != {CNT_W{1'b1}})) begin
            cnt_next = match_cnt + CNT_W'(1);
        end
    end

    // Datapath and configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_cfg   <= '0;
            len_cfg   <= 5'd0;
            ovl_cfg   <= 1'b0;
            hist      <= '0;
            fill      <= 5'd0;
            match     <= 1'b0;
            match_cnt <= '0;
        end else begin
            pat_cfg   <= pat_cfg_next;
            len_cfg   <= len_cfg_next;
            ovl_cfg   <= ovl_cfg_next;
            hist      <= hist_next;
            fill      <= fill_next;
            match     <= match_next;
            match_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_seq_detector_prog.sv
// Testbench for seq_detector_prog. Two instances share the inputs: one uses
// the default 8-bit counter and one uses a 2-bit counter to exercise
// saturation. The expected behaviour comes from a queue-based reference
// model: the bits seen since the last restart are compared with the pattern.
module tb_seq_detector_prog;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] pat;
    logic [4:0] len;
    logic       ovl;
    logic       din_valid;
    logic       din;
    logic       cnt_clr;

    logic       match8, armed8;
    logic [7:0] cnt8;
    logic       match2, armed2;
    logic [1:0] cnt2;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    bit         m_armed;
    bit   [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    bit         seq[$];     // bits eligible for the next match, oldest first
    int         e_cnt8;
    int         e_cnt2;
    bit         exp_match;

    seq_detector_prog #(.MAX_LEN(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .load(load), .pat(pat), .len(len), .ovl(ovl),
        .din_valid(din_valid), .din(din), .cnt_clr(cnt_clr),
        .match(match8), .match_cnt(cnt8), .armed(armed8)
    );

    seq_detector_prog #(.MAX_LEN(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .load(load), .pat(pat), .len(len), .ovl(ovl),
        .din_valid(din_valid), .din(din), .cnt_clr(cnt_clr),
        .match(match2), .match_cnt(cnt2), .armed(armed2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model for one clock edge.
    task automatic model_step(input bit l, input bit [7:0] p, input int ln,
                              input bit o, input bit v, input bit d,
                              input bit c);
        bit ok;
        exp_match = 1'b0;
        if (l) begin
            m_pat   = p;
            m_len   = (ln > 8) ? 8 : ln;
            m_ovl   = o;
            m_armed = (ln != 0);
            seq.delete();
        end else if (m_armed && v) begin
            seq.push_back(d);
            if (seq.size() >= m_len) begin
                ok = 1'b1;
                // The last received bit is compared with pattern bit 0.
                for (int k = 0; k < m_len; k++) begin
                    if (seq[seq.size() - 1 - k] != m_pat[k]) ok = 1'b0;
                end
                if (ok) begin
                    exp_match = 1'b1;
                    if (!m_ovl) seq.delete();
                end
            end
            if (seq.size() > 32) void'(seq.pop_front());
        end
        if (c) begin
            e_cnt8 = 0;
            e_cnt2 = 0;
        end else if (exp_match) begin
            if (e_cnt8 < 255) e_cnt8++;
            if (e_cnt2 < 3) e_cnt2++;
        end
    endtask

    // Drive one cycle, update the model at the edge, then compare #1 later.
    task automatic cycle(input string tag, input bit l, input bit [7:0] p,
                         input bit [4:0] ln, input bit o, input bit v,
                         input bit d, input bit c);
        load = l; pat = p; len = ln; ovl = o;
        din_valid = v; din = d; cnt_clr = c;
        @(posedge clk);
        model_step(l, p, int'(ln), o, v, d, c);
        #1;
        check({tag, "_match"},  32'(match8), 32'(exp_match));
        check({tag, "_match2"}, 32'(match2), 32'(exp_match));
        check({tag, "_cnt8"},   32'(cnt8),   32'(e_cnt8));
        check({tag, "_cnt2"},   32'(cnt2),   32'(e_cnt2));
        check({tag, "_armed"},  32'(armed8), 32'(m_armed));
    endtask

    task automatic bit_in(input string tag, input bit d);
        cycle(tag, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic gap(input string tag);
        cycle(tag, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load_cfg(input string tag, input bit [7:0] p,
                            input bit [4:0] ln, input bit o);
        cycle(tag, 1'b1, p, ln, o, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_cnt(input string tag);
        cycle(tag, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Asynchronous reset pulse applied between clock edges. The outputs are
    // checked while reset is still asserted.
    task automatic apply_reset(input string tag);
        load = 0; pat = 0; len = 0; ovl = 0;
        din_valid = 0; din = 0; cnt_clr = 0;
        rst = 1'b1;
        #2;
        m_armed = 0; m_pat = 0; m_len = 0; m_ovl = 0;
        seq.delete();
        e_cnt8 = 0; e_cnt2 = 0; exp_match = 0;
        check({tag, "_match"}, 32'(match8), 32'd0);
        check({tag, "_cnt8"},  32'(cnt8),   32'd0);
        check({tag, "_cnt2"},  32'(cnt2),   32'd0);
        check({tag, "_armed"}, 32'(armed8), 32'd0);
        check({tag, "_armed2"}, 32'(armed2), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        bit [3:0] p1011;
        bit [7:0] pa5;
        p1011 = 4'b1011;
        pa5   = 8'hA5;

        apply_reset("reset");

        // IDLE: samples are ignored.
        bit_in("idle", 1'b1);
        bit_in("idle", 1'b1);

        // Overlapping 1011 over stream 1011011 -> matches after bits 4 and 7.
        load_cfg("ovl1011_load", 8'b0000_1011, 5'd4, 1'b1);
        for (int i = 0; i < 7; i++) begin
            bit [6:0] s;
            s = 7'b1011011;
            bit_in("ovl1011", s[6 - i]);
            if (i == 3 || i == 6) check("ovl1011_pulse", 32'(match8), 32'd1);
        end
        check("ovl1011_total", 32'(cnt8), 32'd2);

        // Non-overlapping: single match after bit 4.
        clear_cnt("clr_a");
        load_cfg("nov1011_load", 8'b0000_1011, 5'd4, 1'b0);
        for (int i = 0; i < 7; i++) begin
            bit [6:0] s;
            s = 7'b1011011;
            bit_in("nov1011", s[6 - i]);
        end
        check("nov1011_total", 32'(cnt8), 32'd1);

        // 111 over five ones: three overlapping matches, or one without overlap.
        clear_cnt("clr_b");
        load_cfg("ovl111_load", 8'b0000_0111, 5'd3, 1'b1);
        for (int i = 0; i < 5; i++) bit_in("ovl111", 1'b1);
        check("ovl111_total", 32'(cnt8), 32'd3);
        clear_cnt("clr_c");
        load_cfg("nov111_load", 8'b0000_0111, 5'd3, 1'b0);
        for (int i = 0; i < 5; i++) bit_in("nov111", 1'b1);
        check("nov111_total", 32'(cnt8), 32'd1);

        // One-bit pattern: the 2-bit counter saturates, then clear beats match.
        clear_cnt("clr_d");
        load_cfg("len1_load", 8'h01, 5'd1, 1'b1);
        for (int i = 0; i < 6; i++) bit_in("len1", 1'b1);
        check("sat_cnt2", 32'(cnt2), 32'd3);
        check("sat_cnt8", 32'(cnt8), 32'd6);
        cycle("clr_vs_match", 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("clr_vs_match_cnt2", 32'(cnt2), 32'd0);

        // Reload mid-stream drops partial history; a sample in the load cycle
        // is dropped as well.
        load_cfg("reload_a", 8'b0000_1011, 5'd4, 1'b1);
        bit_in("reload", 1'b1); bit_in("reload", 1'b0); bit_in("reload", 1'b1);
        cycle("reload_b", 1'b1, 8'b0000_1011, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        bit_in("reload_first", 1'b1);
        check("reload_nomatch", 32'(match8), 32'd0);
        bit_in("reload", 1'b0); bit_in("reload", 1'b1); bit_in("reload", 1'b1);
        check("reload_match", 32'(match8), 32'd1);

        // Random valid gaps of 0..3 cycles between the bits of 1011.
        clear_cnt("clr_e");
        load_cfg("gap_load", 8'b0000_1011, 5'd4, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            int g;
            g = $urandom_range(0, 3);
            for (int j = 0; j < g; j++) gap("gap_idle");
            bit_in("gap_bit", p1011[i]);
        end
        gap("gap_after");
        check("gap_one_pulse", 32'(match8), 32'd0);
        check("gap_total", 32'(cnt8), 32'd1);

        // A pattern straddling reset must not match.
        bit_in("rst_pre", 1'b1); bit_in("rst_pre", 1'b0); bit_in("rst_pre", 1'b1);
        apply_reset("rst_mid");
        load_cfg("rst_load", 8'b0000_1011, 5'd4, 1'b1);
        bit_in("rst_post", 1'b1);
        check("rst_straddle", 32'(match8), 32'd0);

        // Oversized length is clamped to 8; len 0 disarms.
        load_cfg("clamp_load", pa5, 5'd20, 1'b0);
        for (int i = 7; i >= 0; i--) bit_in("clamp", pa5[i]);
        check("clamp_match", 32'(match8), 32'd1);
        load_cfg("disarm", 8'h00, 5'd0, 1'b0);
        check("disarm_armed2", 32'(armed2), 32'd0);

        // Randomized traffic against the reference model.
        load_cfg("rnd_load", 8'($urandom), 5'($urandom_range(1, 4)), 1'($urandom));
        for (int i = 0; i < 400; i++) begin
            bit       l, o, v, d, c;
            bit [7:0] p;
            bit [4:0] ln;
            l  = ($urandom_range(0, 29) == 0);
            p  = 8'($urandom);
            ln = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 20))
                                              : 5'($urandom_range(1, 4));
            o  = 1'($urandom);
            v  = ($urandom_range(0, 3) != 0);
            d  = 1'($urandom);
            c  = ($urandom_range(0, 39) == 0);
            if (i == 200) apply_reset("rnd_reset");
            cycle("rnd", l, p, ln, o, v, d, c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detector_prog.md
SEQ_DETECTOR_PROG -- requirements
Module: seq_detector_prog

Interface
REQ-001 SHALL provide parameter MAX_LEN, default 8, maximum pattern length in bits (legal 2..16).
REQ-002 SHALL provide parameter CNT_W, default 8, width of the match counter.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port load  input  1  capture pat/len/ovl into configuration registers.
REQ-006 SHALL have port pat  input  MAX_LEN  pattern; bit len-1 is received first, bit 0 last.
REQ-007 SHALL have port len  input  5  pattern length in bits.
REQ-008 SHALL have port ovl  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-009 SHALL have port din_valid  input  1  din is sampled this cycle.
REQ-010 SHALL have port din  input  1  serial data bit.
REQ-011 SHALL have port cnt_clr  input  1  synchronous clear of match_cnt.
REQ-012 SHALL have port match  output  1  registered one-cycle pulse on pattern completion.
REQ-013 SHALL have port match_cnt  output  CNT_W  saturating count of matches.
REQ-014 SHALL have port armed  output  1  high once a valid configuration is loaded.

Function
REQ-015 SHALL implement FSM states IDLE (unconfigured) and ARMED; reset enters IDLE.
REQ-016 IDLE -> ARMED on load with 1 <= len; ARMED -> IDLE on load with len == 0; otherwise state holds.
REQ-017 len > MAX_LEN SHALL be clamped to MAX_LEN at capture.
REQ-018 In IDLE, SHALL ignore din_valid: no history update, match stays 0.
REQ-019 SHALL keep history register hist[MAX_LEN-1:0] and fill counter fill (0..MAX_LEN, saturating).
REQ-020 In ARMED with din_valid=1, SHALL shift hist left, insert din at bit 0, and increment fill.
REQ-021 A match SHALL occur when, after the shift, fill >= len_cfg and hist[len_cfg-1:0] == pat_cfg[len_cfg-1:0].
REQ-022 match SHALL be asserted for exactly the one cycle following the clk edge that sampled the completing bit (latency 1); it SHALL be 0 otherwise, including cycles with din_valid=0.
REQ-023 On a match with ovl_cfg=0, fill SHALL become 0, so no bit is shared between matches.
REQ-024 On a match with ovl_cfg=1, fill SHALL be retained.
REQ-025 load SHALL clear hist, fill and match, and takes priority over din_valid in the same cycle; that sample is dropped.
REQ-026 match_cnt SHALL increment by 1 per match and saturate at 2^CNT_W-1.
REQ-027 cnt_clr SHALL have priority over a simultaneous increment, leaving match_cnt = 0.
REQ-028 load SHALL NOT clear match_cnt.
REQ-029 armed SHALL equal (state == ARMED), registered.

Reset
REQ-030 rst SHALL set state=IDLE, hist=0, fill=0, pat_cfg=0, len_cfg=0, ovl_cfg=0, match=0, match_cnt=0, armed=0, immediately and independent of clk.
REQ-031 Reset asserted mid-sequence SHALL discard partial history; a pattern straddling reset SHALL NOT match.

Verification
REQ-032 load pat=4'b1011, len=4, ovl=1; stream 1,0,1,1,0,1,1 -> match pulses after bits 4 and 7; match_cnt=2.
REQ-033 Same stream, ovl=0 -> single match after bit 4; match_cnt=1.
REQ-034 pat=3'b111, len=3, ovl=1; five 1s -> matches after bits 3, 4, 5; with ovl=0 -> match after bit 3 only.
REQ-035 CNT_W=2, pattern len=1, pat=1; six 1s -> match_cnt saturates at 3; cnt_clr together with a match -> match_cnt=0.
REQ-036 load pat=1011 len=4 mid-stream after 1,0,1 -> the next 1 gives no match; the full 1,0,1,1 sequence afterwards gives a match.
REQ-037 din_valid gaps of 0-3 cycles between bits of 1011 -> one match, pulse exactly 1 cycle; rst pulse after 1,0,1 followed by load and 1 -> no match.
